veririsc_controller: RTL and testbench

//  Sequencer for the VeriRISC datapath: an 8-phase instruction cycle decoded with the current opcode.

---
 rtl/veririsc_controller.sv | 126 ++++++++++++
 tb/tb_veririsc_controller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/veririsc_controller.sv
// rtl/veririsc_controller.sv - VeriRISC 8-phase instruction sequencer
// Phase counter plus halted flag; every strobe is decoded combinationally from them and the opcode.
module veririsc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   alu_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (phase_q == OP_ADDR && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_t'(phase_q + 3'd1);
      end
    end
  end

  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign phase  = phase_q;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    // Once halted, everything but halt is suppressed, so the PC cannot step again.
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: rd = alu_op;
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          inc_pc = (opcode == OP_JMP);
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  a_wr_data_e: assert property (@(posedge clk) disable iff (!rst_n) wr |-> data_e);
  a_jmp_only: assert property (@(posedge clk) disable iff (!rst_n)
    (ld_pc && inc_pc) |-> (phase_q == STORE && opcode == OP_JMP));
  a_ld_ir_ph: assert property (@(posedge clk) disable iff (!rst_n)
    ld_ir |-> (phase_q == INST_LOAD || phase_q == IDLE));
  a_rd_wr: assert property (@(posedge clk) disable iff (!rst_n) !(rd && wr));

endmodule

// File: tb/tb_veririsc_controller.sv
// tb/tb_veririsc_controller.sv - scoreboard bench for veririsc_controller
// Expected strobe vectors are queued when inputs are driven and compared at the falling edge.
module tb_veririsc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt;
  logic [2:0] phase;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_q[$];
  logic [2:0]  m_phase;
  bit          m_halted;

  veririsc_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Vector order: sel rd ld_ir ld_ac ld_pc inc_pc wr data_e halt phase[2:0]
  function automatic logic [11:0] model_out(logic [2:0] p, bit h, logic [2:0] o, logic z);
    bit alu, sto, jmp;
    logic [8:0] s;
    alu = (o == 3'd2) || (o == 3'd3) || (o == 3'd4) || (o == 3'd5);
    sto = (o == 3'd6);
    jmp = (o == 3'd7);
    if (h) return {9'b0_0000_0001, p};
    case (p)
      3'd0: s = 9'b1_0000_0000;
      3'd1: s = 9'b1_1000_0000;
      3'd2, 3'd3: s = 9'b1_1100_0000;
      3'd4: s = {5'b0_0000, 1'b1, 2'b00, o == 3'd0};
      3'd5: s = {1'b0, alu, 7'b0};
      3'd6: s = {1'b0, alu, 2'b00, jmp, (o == 3'd1) && z, 1'b0, sto, 1'b0};
      default: s = {1'b0, alu, 1'b0, alu, jmp, jmp, sto, sto, 1'b0};
    endcase
    return {s, p};
  endfunction

  task automatic cyc(input logic r, input logic [2:0] o, input logic z, output logic inc);
    logic [11:0] e;
    rst_n = r; opcode = o; zero = z;
    exp_q.push_back(model_out(m_phase, m_halted, o, z));
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("out_ph%0d_op%0d", m_phase, o),
          {4'h0, sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt, phase}, {4'h0, e});
    inc = inc_pc;
    @(posedge clk);
    if (!r) begin
      m_phase = 3'd0; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_phase == 3'd4 && o == 3'd0) m_halted = 1'b1;
      else m_phase = m_phase + 3'd1;
    end
    #1;
  endtask

  // One full instruction from phase 0; opcode is random before phase 3.
  task automatic run_instr(input logic [2:0] op, input logic z5, input logic z6, output int incs);
    logic inc;
    logic [2:0] o;
    logic z;
    incs = 0;
    for (int p = 0; p < 8; p++) begin
      o = (p >= 3) ? op : 3'($urandom_range(7));
      z = (p == 5) ? z5 : (p == 6) ? z6 : 1'($urandom_range(1));
      cyc(1'b1, o, z, inc);
      if (inc) incs++;
    end
  endtask

  initial begin
    int incs;
    logic inc;
    rst_n = 1'b0; opcode = 3'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_phase = 3'd0; m_halted = 1'b0;

    cyc(1'b0, 3'd2, 1'b0, inc);
    check("reset_phase", {13'd0, phase}, 16'd0);

    // Reset asserted mid-instruction at phase 5
    while (m_phase != 3'd5) cyc(1'b1, 3'd2, 1'b0, inc);
    cyc(1'b0, 3'd2, 1'b1, inc);
    cyc(1'b0, 3'd2, 1'b1, inc);
    check("reset_halt", {15'd0, halt}, 16'd0);

    run_instr(3'd2, 1'b0, 1'b1, incs);
    check("add_incs", 16'(incs), 16'd1);
    run_instr(3'd6, 1'b1, 1'b0, incs);
    run_instr(3'd1, 1'b1, 1'b1, incs);
    check("skz_z1_incs", 16'(incs), 16'd2);
    run_instr(3'd1, 1'b0, 1'b0, incs);
    check("skz_z0_incs", 16'(incs), 16'd1);
    run_instr(3'd1, 1'b1, 1'b0, incs);
    check("skz_z5only_incs", 16'(incs), 16'd1);
    run_instr(3'd7, 1'b0, 1'b1, incs);
    check("jmp_incs", 16'(incs), 16'd2);
    for (int op = 3; op <= 5; op++) run_instr(3'(op), 1'b1, 1'b1, incs);

    // HLT: phase freezes at 4 and the PC steps only once
    run_instr(3'd0, 1'b0, 1'b0, incs);
    check("hlt_incs", 16'(incs), 16'd1);
    incs = 0;
    for (int i = 0; i < 22; i++) begin
      cyc(1'b1, 3'($urandom_range(7)), 1'($urandom_range(1)), inc);
      if (inc) incs++;
    end
    check("halted_incs", 16'(incs), 16'd0);
    check("halted_phase", {13'd0, phase}, 16'd4);
    cyc(1'b0, 3'd0, 1'b0, inc);
    run_instr(3'd2, 1'b0, 1'b0, incs);
    run_instr(3'd6, 1'b0, 1'b0, incs);

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
